// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a first-word-fall-through FIFO with sticky error flags.
// Define UART_RX_FIFO_PARITY_EN to expect a parity bit (PARITY_ODD selects odd parity).
module uart_rx_fifo #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 12
`ifdef UART_RX_FIFO_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   pop,
    input  logic                   clr_err,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   frame_err,
    output logic                   parity_err
);
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam int BW      = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic                   rx_s1, rx_s2;
    logic [1:0]             sync_fill;
    logic                   armed, start_edge, tick;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   push_req, frame_evt, par_bad;
    logic                   push_ok, pop_ok, ovf_evt;
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   mem [DEPTH];

    // sync_fill keeps the reset value of the synchroniser from counting as a real high sample.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            sync_fill <= '0;
            armed     <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            if (state == IDLE && rx_s2 && sync_fill[1])
                armed <= 1'b1;
            else if (start_edge)
                armed <= 1'b0;
        end
    end

    assign start_edge = (state == IDLE) && armed && !rx_s2;
    assign tick       = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_edge) state_nxt = START;
            START:  if (tick) state_nxt = rx_s2 ? IDLE : DATA;
            DATA:   if (tick && bit_cnt == BW'(DATA_BITS - 1))
`ifdef UART_RX_FIFO_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
            PARITY: if (tick) state_nxt = STOP;
            STOP:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_PARITY_EN
    logic par_evt;
`endif

    always_comb begin
        push_req  = 1'b0;
        frame_evt = 1'b0;
`ifdef UART_RX_FIFO_PARITY_EN
        par_evt   = 1'b0;
        if (state == PARITY && tick)
            par_evt = ((^shreg) ^ rx_s2) != PARITY_ODD;
`endif
        if (state == STOP && tick) begin
            push_req  = rx_s2 && !par_bad;
            frame_evt = !rx_s2;
        end
    end

    // Baud counter idles at half a bit so the first sample lands mid start bit.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            cnt     <= CW'(BIT_CYC / 2);
            bit_cnt <= '0;
        end else if (tick) begin
            cnt <= CW'(BIT_CYC);
            if (state == DATA) begin
                shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef UART_RX_FIFO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) par_bad <= 1'b0;
        else if (par_evt)         par_bad <= 1'b1;
    end
`else
    assign par_bad = 1'b0;
`endif

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign almost_full = (level >= (AW + 1)'(AF_LEVEL));
    assign rd_data     = mem[rd_ptr[AW-1:0]];
    assign pop_ok      = pop && !empty;
    assign push_ok     = push_req && (!full || pop);
    assign ovf_evt     = push_req && full && !pop;

    // NOTE: storage is not reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovf_evt)      overflow  <= 1'b1;
            else if (clr_err) overflow  <= 1'b0;
            if (frame_evt)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)          parity_err <= 1'b0;
        else if (par_evt) parity_err <= 1'b1;
        else if (clr_err) parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (104 clocks per bit).
// Define UART_RX_FIFO_PARITY_EN here as well to exercise the even-parity frames.
module tb_uart_rx_fifo;
    localparam int BIT = 104;
`ifdef UART_RX_FIFO_PARITY_EN
    localparam int PAR_BITS = 1;
    logic force_bad_par = 1'b0;
`else
    localparam int PAR_BITS = 0;
`endif
    // Clocks into the stop bit at which the receiver takes its stop sample.
    localparam int STOP_OFF = 64 + PAR_BITS;

    logic       clk = 1'b0;
    logic       rst, rx, pop, clr_err;
    logic [7:0] rd_data;
    logic       empty, full, almost_full, overflow, frame_err, parity_err;
    logic [4:0] level;
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .rx(rx), .pop(pop), .clr_err(clr_err),
        .rd_data(rd_data), .empty(empty), .full(full), .level(level),
        .almost_full(almost_full), .overflow(overflow), .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one frame; optional pop/clr_err pulse lands on the stop-sample clock edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic do_pop, input logic do_clr);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_FIFO_PARITY_EN
        rx = (^data) ^ force_bad_par;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (STOP_OFF) @(negedge clk);
        pop     = do_pop;
        clr_err = do_clr;
        @(negedge clk);
        pop     = 1'b0;
        clr_err = 1'b0;
        repeat (BIT - STOP_OFF - 1) @(negedge clk);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rx = 1'b1; pop = 1'b0; clr_err = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_perr", 32'(parity_err), 0);
        repeat (10) @(negedge clk);

        // Two back-to-back frames, head stays on the first.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check("t1_rd0", 32'(rd_data), 32'h55);
        check("t1_empty", 32'(empty), 0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        check("t1_level2", 32'(level), 2);
        check("t1_head", 32'(rd_data), 32'h55);
        pop_one();
        check("t1_rd1", 32'(rd_data), 32'hA3);
        check("t1_level1", 32'(level), 1);
        pop_one();
        check("t1_drained", 32'(empty), 1);

        // Fill past capacity.
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 10) check("t2_af_11", 32'(almost_full), 0);
            if (i == 11) check("t2_af_12", 32'(almost_full), 1);
            if (i == 14) check("t2_full_15", 32'(full), 0);
            if (i == 15) begin
                check("t2_full_16", 32'(full), 1);
                check("t2_ovf_16", 32'(overflow), 0);
            end
        end
        check("t2_ovf_17", 32'(overflow), 1);
        check("t2_level", 32'(level), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_pop%0d", i), 32'(rd_data), 32'(i));
            pop_one();
        end
        check("t2_empty", 32'(empty), 1);
        check("t2_af_end", 32'(almost_full), 0);
        clr_pulse();
        check("t2_ovf_clr", 32'(overflow), 0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 16; i++) send_frame(8'(32 + i), 1'b1, 1'b0, 1'b0);
        check("t3_full", 32'(full), 1);
        send_frame(8'h77, 1'b1, 1'b1, 1'b0);
        check("t3_level", 32'(level), 16);
        check("t3_ovf", 32'(overflow), 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t3_pop%0d", i), 32'(rd_data), 32'(32 + i));
            pop_one();
        end
        check("t3_last", 32'(rd_data), 32'h77);
        pop_one();
        check("t3_empty", 32'(empty), 1);

        // Short low glitch: start resample sees high, nothing happens.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_empty", 32'(empty), 1);
        check("glitch_ferr", 32'(frame_err), 0);

        // Framing errors and clearing.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t4_ferr", 32'(frame_err), 1);
        check("t4_empty", 32'(empty), 1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        clr_pulse();
        check("t4_ferr_clr", 32'(frame_err), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("t4_set_wins", 32'(frame_err), 1);
        rx = 1'b1;
        repeat (20) @(negedge clk);

        // Reset mid-frame with the line held low afterwards.
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ferr_rst", 32'(frame_err), 0);
        check("t5_empty_rst", 32'(empty), 1);
        repeat (2000) @(negedge clk);
        check("t5_no_push", 32'(empty), 1);
        check("t5_level", 32'(level), 0);
        check("t5_ferr_low", 32'(frame_err), 0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check("t5_rd", 32'(rd_data), 32'h81);
        check("t5_level1", 32'(level), 1);
        pop_one();

`ifdef UART_RX_FIFO_PARITY_EN
        force_bad_par = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check("t6_good_rd", 32'(rd_data), 32'h07);
        check("t6_good_perr", 32'(parity_err), 0);
        pop_one();
        force_bad_par = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        force_bad_par = 1'b0;
        check("t6_bad_perr", 32'(parity_err), 1);
        check("t6_bad_empty", 32'(empty), 1);
        clr_pulse();
        check("t6_perr_clr", 32'(parity_err), 0);
`else
        check("t6_perr_tied", 32'(parity_err), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with integrated FIFO, successor to the single-clock RX ring buffer used by the text-game front end. Block contents:
- Self-contained oversampling RX state machine.
- Power-of-two FIFO with first-word-fall-through read port, fill level and almost-full flag.
- Sticky overflow and framing-error flags.
- Synchronous reset.

Sits between the RX pad and the command parser, which drains it via pop.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate; bit period BIT_CYC = CLK_FREQ/BAUD (integer truncation, 104 at defaults)
DATA_BITS, 8, data bits per frame, legal 5..9
DEPTH, 16, FIFO entries, power of two, >=2
AF_LEVEL, 12, almost_full asserted when level >= AF_LEVEL

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
rx  input  1  asynchronous serial line, idle high
pop  input  1  consume head entry; ignored when empty
clr_err  input  1  clears sticky overflow/frame_err/parity_err
rd_data  output  DATA_BITS  head entry; valid while empty=0
empty  output  1  FIFO holds no entries
full  output  1  level == DEPTH
level  output  log2(DEPTH)+1  current entry count
almost_full  output  1  level >= AF_LEVEL
overflow  output  1  sticky: a received byte was dropped because FIFO full
frame_err  output  1  sticky: stop bit sampled low
parity_err  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (rst=1 at clock edge):
  - FSM goes to IDLE; FIFO pointers go to 0, so empty=1, full=0, level=0, almost_full=0.
  - overflow, frame_err and parity_err go to 0.
  - Synchroniser flops go to 1; armed flag goes to 0.
  - rd_data content after reset is don't-care.
  - Reset mid-frame abandons the partial frame; nothing is pushed.
- rx passes through a 2-flop synchroniser (2-cycle latency) before any use.
- Start detection: in IDLE, armed is set after a synchronised high sample. A falling edge while armed starts a frame. After reset, a line held low never starts a frame until it has returned high.
- FSM:
  - IDLE -> START on start edge; baud counter loads BIT_CYC/2.
  - START: at count 0, resample. If low -> DATA (counter BIT_CYC). If high -> IDLE (glitch, no error).
  - DATA: sample each bit at count 0, LSB first, shifting into the shift register. After DATA_BITS samples -> PARITY if enabled, else STOP.
  - STOP: sample at count 0. If 1 -> push byte, then IDLE. If 0 -> set frame_err, discard byte, IDLE; armed is cleared until the line returns high.
- Push latency: the byte is written on the stop-sample cycle. empty deasserts the next cycle.
- FIFO:
  - Circular buffer with (log2(DEPTH)+1)-bit read/write pointers. Wrap is natural modulo 2*DEPTH; full when the MSBs differ and the low bits are equal.
  - rd_data = mem[rd_ptr low bits], combinational from the head.
  - pop while empty: no effect.
- Push while full without pop: new byte dropped, stored data untouched, overflow set.
- Push and pop in the same cycle:
  - If full, both occur; no overflow; level unchanged.
  - If empty, the push occurs and the pop is ignored.
- level is registered and updated every cycle with (+push accepted) - (pop accepted). almost_full and full are derived from level.
- Error flags:
  - clr_err clears all sticky flags.
  - If clr_err coincides with a new error event, the set wins.

Optional Feature:
Macro UART_RX_FIFO_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even).
  - The FSM inserts a PARITY state after DATA and samples one parity bit at mid-bit.
  - Mismatch sets parity_err and discards the byte; the STOP check still runs.
- Undefined:
  - No parity bit is expected; the frame is start + DATA_BITS + stop.
  - parity_err is tied to 0.

Test Plan:
1. Defaults. Send 0x55, 0xA3 at 104 clk/bit -> rd_data=0x55, empty=0 within 3 cycles of the second-frame stop sample; level=2; pop -> rd_data=0xA3, level=1.
2. Send 17 bytes 0x00..0x10 with no pop -> full=1 after the 16th, overflow=1 after the 17th; 16 pops return 0x00..0x0F in order; almost_full=1 from level 12.
3. Fill to 16, then pop in the same cycle as the stop sample of byte 0x77 -> level stays 16, overflow=0, last entry read is 0x77.
4. Frame 0x3C with stop bit forced low -> frame_err=1, empty stays 1; clr_err pulse -> frame_err=0.
5. Hold rx low, assert rst mid-frame, release with rx still low for 2000 cycles -> no push, FSM IDLE. Then send 0x81 -> received correctly.
6. With UART_RX_FIFO_PARITY_EN and PARITY_ODD=0: send 0x07 with parity 1 -> accepted. Send 0x07 with parity 0 -> parity_err=1, not pushed.
